// File: rtl/sy_pkg.sv
// sy_pkg: D$ geometry defaults and the flush controller state encoding.
package sy_pkg;
  localparam int DC_SETS       = 64;
  localparam int DC_WAYS       = 4;
  localparam int DC_LINE_BYTES = 64;
  localparam int PAWTH         = 56;

  typedef enum logic [3:0] {
    IDLE,
    DRAIN,
    META_RD,
    META_CHK,
    EVICT,
    WB_WAIT,
    INVAL,
    ACK,
    WAIT_LOW
  } flush_fsm_e;
endpackage

// File: rtl/sy_dcache_flush_ctrl.sv
// sy_dcache_flush_ctrl: walks every D$ set/way on a flush request, writing back dirty lines and invalidating valid ones.
module sy_dcache_flush_ctrl #(
  parameter int SETS       = sy_pkg::DC_SETS,
  parameter int WAYS       = sy_pkg::DC_WAYS,
  parameter int LINE_BYTES = sy_pkg::DC_LINE_BYTES,
  parameter int PAWTH      = sy_pkg::PAWTH,
  parameter int TAG_W      = PAWTH - $clog2(SETS) - $clog2(LINE_BYTES),
  localparam int SW        = $clog2(SETS),
  localparam int WW        = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int OB        = $clog2(LINE_BYTES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ppl_dcache_flush_i,
  output logic             ppl_dcache_flush_ack_o,
  output logic             flush_busy_o,
  input  logic             cache_idle_i,
  output logic             meta_rd_o,
  output logic             meta_we_o,
  output logic [SW-1:0]    meta_set_o,
  output logic [WW-1:0]    meta_way_o,
  input  logic             meta_valid_i,
  input  logic             meta_dirty_i,
  input  logic [TAG_W-1:0] meta_tag_i,
  output logic             evict_req_o,
  output logic [PAWTH-1:0] evict_addr_o,
  output logic [SW-1:0]    evict_set_o,
  output logic [WW-1:0]    evict_way_o,
  input  logic             evict_gnt_i,
  input  logic             evict_done_i
);
  import sy_pkg::*;

  flush_fsm_e       state, state_n;
  logic [SW-1:0]    set_q, set_n, eset_q;
  logic [WW-1:0]    way_q, way_n, eway_q;
  logic [TAG_W-1:0] tag_q;
  logic             latch, step, last_way, last_set;

  assign last_way = way_q == WW'(WAYS - 1);
  assign last_set = set_q == SW'(SETS - 1);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      set_q  <= '0;
      way_q  <= '0;
      tag_q  <= '0;
      eset_q <= '0;
      eway_q <= '0;
    end else begin
      state <= state_n;
      set_q <= set_n;
      way_q <= way_n;
      if (latch) begin
        tag_q  <= meta_tag_i;
        eset_q <= set_q;
        eway_q <= way_q;
      end
    end
  end

  // step is the zero-cycle advance to the next line, taken from META_CHK or INVAL
  always_comb begin
    state_n = state;
    set_n   = set_q;
    way_n   = way_q;
    latch   = 1'b0;
    step    = 1'b0;
    case (state)
      IDLE:     state_n = ppl_dcache_flush_i ? DRAIN : IDLE;
      DRAIN:    state_n = cache_idle_i ? META_RD : DRAIN;
      META_RD:  state_n = META_CHK;
      META_CHK: begin
        step    = !meta_valid_i;
        latch   = meta_valid_i && meta_dirty_i;
        state_n = meta_dirty_i ? EVICT : INVAL;
      end
      EVICT:    state_n = !evict_gnt_i ? EVICT : evict_done_i ? INVAL : WB_WAIT;
      WB_WAIT:  state_n = evict_done_i ? INVAL : WB_WAIT;
      INVAL:    step = 1'b1;
      ACK: begin
        state_n = WAIT_LOW;
        set_n   = '0;
        way_n   = '0;
      end
      WAIT_LOW: state_n = ppl_dcache_flush_i ? WAIT_LOW : IDLE;
      default:  state_n = IDLE;
    endcase
    if (step) begin
      way_n   = last_way ? '0 : way_q + WW'(1);
      set_n   = last_way ? set_q + SW'(1) : set_q;
      state_n = (last_way && last_set) ? ACK : META_RD;
    end
  end

  assign flush_busy_o           = !(state inside {IDLE, WAIT_LOW});
  assign ppl_dcache_flush_ack_o = state == ACK;
  assign meta_rd_o              = state == META_RD;
  assign meta_we_o              = state == INVAL;
  assign meta_set_o             = set_q;
  assign meta_way_o             = way_q;
  assign evict_req_o            = state == EVICT;
  assign evict_addr_o           = {tag_q, eset_q, {OB{1'b0}}};
  assign evict_set_o            = eset_q;
  assign evict_way_o            = eway_q;
endmodule

// File: tb/tb_sy_dcache_flush_ctrl.sv
// tb_sy_dcache_flush_ctrl: table-driven and randomized flush walks checked against a line-level model.
module tb_sy_dcache_flush_ctrl;
  localparam int SETS = 4, WAYS = 2, LINE_BYTES = 64, PAWTH = 56;
  localparam int SW = 2, WW = 1, OB = 6, TAG_W = PAWTH - SW - OB, N = SETS * WAYS;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic req = 1'b0, idle = 1'b1, mv = 1'b0, md = 1'b0, egnt = 1'b0, edone = 1'b0;
  logic [TAG_W-1:0] mt = '0;
  logic ack, busy, mrd, mwe, ereq;
  logic [SW-1:0] mset, eset;
  logic [WW-1:0] mway, eway;
  logic [PAWTH-1:0] eaddr;

  sy_dcache_flush_ctrl #(.SETS(SETS), .WAYS(WAYS), .LINE_BYTES(LINE_BYTES), .PAWTH(PAWTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ppl_dcache_flush_i(req), .ppl_dcache_flush_ack_o(ack), .flush_busy_o(busy),
    .cache_idle_i(idle),
    .meta_rd_o(mrd), .meta_we_o(mwe), .meta_set_o(mset), .meta_way_o(mway),
    .meta_valid_i(mv), .meta_dirty_i(md), .meta_tag_i(mt),
    .evict_req_o(ereq), .evict_addr_o(eaddr), .evict_set_o(eset), .evict_way_o(eway),
    .evict_gnt_i(egnt), .evict_done_i(edone)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string name;
    int fill, g, d, dly, hold, lat;
  } vec_t;

  logic vmem [N];
  logic dmem [N];
  logic [TAG_W-1:0] tmem [N];
  int checks = 0, errors = 0;
  int g_cfg, d_cfg, dly_cfg, ev_k, wb_j, rd_k, ord_err, early_rd, stab_err, drop_err;
  int n_ack, n_busy, ack_t, busy_after;
  bit in_ev, granted, wb_pend, prev_rd;
  logic [63:0] ev_first;
  int we_q[$];
  logic [63:0] ev_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // {addr, set, way} record for one line, built from the tag array
  function automatic logic [63:0] line_rec(input int i);
    logic [63:0] s, w, a;
    s = 64'(i / WAYS);
    w = 64'(i % WAYS);
    a = (64'(tmem[i]) << (SW + OB)) | (s << OB);
    return (a << (SW + WW)) | (s << WW) | w;
  endfunction

  task automatic fill(input int f);
    for (int i = 0; i < N; i++) begin
      vmem[i] = 1'b0; dmem[i] = 1'b0; tmem[i] = '0;
    end
    if (f == 1) begin vmem[5] = 1'b1; tmem[5] = TAG_W'(8'h1A); end
    if (f == 2) begin vmem[2] = 1'b1; dmem[2] = 1'b1; tmem[2] = TAG_W'(8'h3F); end
  endtask

  task automatic init_walk(input int g, input int d, input int dly);
    g_cfg = g; d_cfg = d; dly_cfg = dly;
    rd_k = 0; ord_err = 0; early_rd = 0; stab_err = 0; drop_err = 0;
    n_ack = 0; n_busy = 0; ack_t = -1; busy_after = -1;
    in_ev = 0; granted = 0; wb_pend = 0; prev_rd = 0;
    we_q.delete(); ev_q.delete();
  endtask

  // One cycle of observation plus meta-array and evict-unit responses, called at negedge
  task automatic drive_cycle(input int c);
    int idx;
    logic [63:0] p;
    idx = int'(mset) * WAYS + int'(mway);
    p = 64'({eaddr, eset, eway});
    if (busy) n_busy++;
    if (c == ack_t + 1) busy_after = int'(busy);
    if (ack) begin
      n_ack++;
      if (ack_t < 0) ack_t = c;
    end
    if (mrd) begin
      if (c < 2 + dly_cfg) early_rd++;
      if (idx != rd_k) ord_err++;
      rd_k++;
      mv = vmem[idx]; md = dmem[idx]; mt = tmem[idx];
    end else if (!prev_rd) begin
      mv = 1'($urandom); md = 1'($urandom); mt = TAG_W'({$urandom, $urandom});
    end
    prev_rd = mrd;
    if (mwe) begin
      we_q.push_back(idx);
      vmem[idx] = 1'b0; dmem[idx] = 1'b0;
    end
    egnt = 1'b0; edone = 1'b0;
    if (ereq) begin
      if (!in_ev) begin
        in_ev = 1; granted = 0; ev_k = 0; ev_first = p; ev_q.push_back(p);
      end else if (p != ev_first) stab_err++;
      if (ev_k == g_cfg) begin
        egnt = 1'b1; granted = 1; wb_j = 0;
        wb_pend = (d_cfg != 0); edone = (d_cfg == 0);
      end
      ev_k++;
    end else begin
      if (in_ev && !granted) drop_err++;
      in_ev = 0;
      if (wb_pend) begin
        wb_j++;
        if (wb_j == d_cfg) begin edone = 1'b1; wb_pend = 0; end
      end
    end
    idle = (c >= 1 + dly_cfg);
  endtask

  task automatic run_walk(input int g, input int d, input int dly, input int hold);
    int c;
    init_walk(g, d, dly);
    @(negedge clk_i);
    req = 1'b1;
    idle = (dly == 0);
    c = 1;
    while (ack_t < 0 && c < 3000) begin @(negedge clk_i); drive_cycle(c); c++; end
    for (int h = 0; h < hold + 1; h++) begin @(negedge clk_i); drive_cycle(c); c++; end
    req = 1'b0;
    for (int h = 0; h < 2; h++) begin @(negedge clk_i); drive_cycle(c); c++; end
  endtask

  task automatic walk_and_check(input string name, input int g, input int d, input int dly,
                                input int hold, input int lat);
    int exp_lat, nv;
    int exp_we[$];
    logic [63:0] exp_ev[$];
    bit ok;
    exp_lat = 2 + dly;
    for (int i = 0; i < N; i++) begin
      if (!vmem[i]) exp_lat += 2;
      else begin
        exp_we.push_back(i);
        if (dmem[i]) begin exp_ev.push_back(line_rec(i)); exp_lat += 4 + g + d; end
        else exp_lat += 3;
      end
    end
    run_walk(g, d, dly, hold);
    if (lat >= 0) chk({name, "_lat_tbl"}, 64'(ack_t), 64'(lat));
    chk({name, "_lat"}, 64'(ack_t), 64'(exp_lat));
    chk({name, "_acks"}, 64'(n_ack), 64'd1);
    chk({name, "_busy_cyc"}, 64'(n_busy), 64'(exp_lat));
    chk({name, "_busy_after"}, 64'(busy_after), 64'd0);
    chk({name, "_rd_cnt"}, 64'(rd_k), 64'(N));
    chk({name, "_rd_order"}, 64'(ord_err), 64'd0);
    chk({name, "_early_rd"}, 64'(early_rd), 64'd0);
    ok = we_q.size() == exp_we.size();
    for (int i = 0; i < we_q.size() && ok; i++) if (we_q[i] != exp_we[i]) ok = 0;
    chk({name, "_we_list"}, 64'(ok), 64'd1);
    ok = ev_q.size() == exp_ev.size();
    for (int i = 0; i < ev_q.size() && ok; i++) if (ev_q[i] != exp_ev[i]) ok = 0;
    chk({name, "_ev_list"}, 64'(ok), 64'd1);
    chk({name, "_ev_stable"}, 64'(stab_err + drop_err), 64'd0);
    nv = 0;
    for (int i = 0; i < N; i++) if (vmem[i]) nv++;
    chk({name, "_all_inval"}, 64'(nv), 64'd0);
  endtask

  initial begin
    vec_t tbl[7];
    int c;
    tbl[0] = '{"empty",      0, 0, 0, 0,  0,  18};
    tbl[1] = '{"clean",      1, 0, 0, 0,  0,  19};
    tbl[2] = '{"dirty",      2, 5, 3, 0,  0,  28};
    tbl[3] = '{"idle_dly",   0, 0, 0, 10, 0,  28};
    tbl[4] = '{"hold",       0, 0, 0, 0,  20, 18};
    tbl[5] = '{"rewalk",     0, 0, 0, 0,  0,  18};
    tbl[6] = '{"dirty_fast", 2, 0, 0, 0,  0,  20};
    repeat (3) @(negedge clk_i);
    chk("rst_ctrl", 64'({ack, busy, mrd, mwe, ereq}), 64'd0);
    chk("rst_idx", 64'({mset, mway, eset, eway}), 64'd0);
    chk("rst_addr", 64'(eaddr), 64'd0);
    rst_i = 1'b1;
    for (int v = 0; v < 7; v++) begin
      fill(tbl[v].fill);
      walk_and_check(tbl[v].name, tbl[v].g, tbl[v].d, tbl[v].dly, tbl[v].hold, tbl[v].lat);
      if (tbl[v].fill == 2)
        chk({tbl[v].name, "_addr"}, ev_q.size() > 0 ? ev_q[0] >> (SW + WW) : '1, 64'h3F40);
    end
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        vmem[i] = 1'($urandom); dmem[i] = 1'($urandom); tmem[i] = TAG_W'({$urandom, $urandom});
      end
      walk_and_check($sformatf("rnd%0d", r), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), 0, -1);
    end
    // async reset while a writeback is outstanding
    fill(0);
    vmem[1] = 1'b1; dmem[1] = 1'b1; tmem[1] = TAG_W'(8'h55);
    init_walk(0, 50, 0);
    @(negedge clk_i);
    req = 1'b1;
    c = 1;
    while (!(granted && !ereq) && c < 200) begin @(negedge clk_i); drive_cycle(c); c++; end
    chk("rst_in_wb_reached", 64'(granted && !ereq), 64'd1);
    #2 rst_i = 1'b0;
    #1;
    chk("arst_ctrl", 64'({ack, busy, mrd, mwe, ereq}), 64'd0);
    chk("arst_idx", 64'({mset, mway, eset, eway}), 64'd0);
    chk("arst_addr", 64'(eaddr), 64'd0);
    req = 1'b0; egnt = 1'b0; edone = 1'b0;
    for (int i = 0; i < 3; i++) begin @(negedge clk_i); if (ack) n_ack++; end
    chk("arst_no_ack", 64'(n_ack), 64'd0);
    rst_i = 1'b1;
    walk_and_check("post_rst", 0, 1, 0, 0, 21);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sy_dcache_flush_ctrl.md
Name: sy_dcache_flush_ctrl

Overview:
- Responder side of the pipeline controller's D$ flush handshake (fence, fence.i).
- Receives a level flush request, drains the data cache, and walks every set/way.
- Dirty lines are written back through the cache's existing evict unit; all valid lines are invalidated.
- Returns a one-cycle ack, then re-arms only after the request drops.
- Sits inside the D$ top, between the pipeline controller and the tag/meta array and evict unit.

Parameters:
- SETS, 64, number of D$ sets (power of 2, ≥2).
- WAYS, 4, associativity (power of 2, ≥1).
- LINE_BYTES, 64, line size in bytes (power of 2).
- PAWTH, 56, physical address width.
- TAG_W, PAWTH-log2(SETS)-log2(LINE_BYTES), tag width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- ppl_dcache_flush_i  in  1  flush request; level, held until ack.
- ppl_dcache_flush_ack_o  out  1  one-cycle flush-complete pulse.
- flush_busy_o  out  1  blocks the normal D$ request path.
- cache_idle_i  in  1  no outstanding load/store/refill in D$.
- meta_rd_o  out  1  meta array read strobe.
- meta_we_o  out  1  meta write: clear valid and dirty.
- meta_set_o  out  log2(SETS)  set index for rd/we.
- meta_way_o  out  max(1,log2(WAYS))  way index for rd/we.
- meta_valid_i  in  1  valid bit; arrives the cycle after meta_rd_o.
- meta_dirty_i  in  1  dirty bit; same timing as meta_valid_i.
- meta_tag_i  in  TAG_W  tag; same timing as meta_valid_i.
- evict_req_o  out  1  writeback request; held until evict_gnt_i.
- evict_addr_o  out  PAWTH  line address {tag,set,0}.
- evict_set_o  out  log2(SETS)  set of the line to write back.
- evict_way_o  out  max(1,log2(WAYS))  way of the line to write back.
- evict_gnt_i  in  1  evict unit accepted the request.
- evict_done_i  in  1  writeback data has left the cache (pulse).

Interface rules:
- One clock, clk_i. rst_i is asynchronous and active-low: state and outputs clear immediately when rst_i = 0; release is synchronous to clk_i.

Behaviour:
- Reset values:
  - State IDLE; set and way counters 0.
  - Every output 0 (flush_busy_o, ack, meta_rd_o, meta_we_o, evict_req_o, indices, address).
- States:
  - IDLE: when req=1 → DRAIN.
  - DRAIN: flush_busy_o=1; when cache_idle_i=1 → META_RD.
  - META_RD: meta_rd_o=1 with set/way counters on meta_set_o/meta_way_o → META_CHK.
  - META_CHK: samples the meta inputs.
    - valid=0 → NEXT.
    - valid=1, dirty=1 → EVICT; latch tag, set, way.
    - valid=1, dirty=0 → INVAL.
  - EVICT: evict_req_o=1 with stable addr/set/way; when evict_gnt_i → WB_WAIT.
  - WB_WAIT: when evict_done_i → INVAL. A done pulse arriving in the grant cycle must be captured.
  - INVAL: meta_we_o=1 for the latched set/way (single cycle) → NEXT.
  - NEXT: combinational decision, no extra cycle; META_CHK and INVAL branch directly.
    - If way = WAYS-1: way←0, set←set+1.
    - Else way←way+1.
    - Last line (set = SETS-1 and way = WAYS-1) → ACK; otherwise → META_RD.
  - ACK: ppl_dcache_flush_ack_o=1 for exactly one cycle; counters reset to 0 → WAIT_LOW.
  - WAIT_LOW: flush_busy_o=0; when req=0 → IDLE.
- flush_busy_o = 1 in DRAIN through ACK inclusive.
- Timing per line (no eviction):
  - Invalid line: 2 cycles.
  - Valid clean line: 3 cycles.
  - Dirty line: 3 cycles + grant wait + writeback wait.
- Counter wrap is internal only; the set counter never wraps mid-walk.
- Requests:
  - Deassertion of req mid-walk is ignored; the walk always completes.
  - A req held high through ACK does not start a second flush.
- Async reset mid-walk: abort to IDLE.
  - No ack is issued.
  - Cache contents may be partially flushed; that is legal because the pipeline controller is also reset.
- evict_req_o must not drop before grant, and its payload must not change before grant.

Decomposition:
- sy_pkg: flush_fsm_e enum; dcache geometry constants (DC_SETS, DC_WAYS, DC_LINE_BYTES, PAWTH) used as parameter defaults.
- No sub-module; a single FSM with counters.

Test Plan:
- Empty cache, SETS=4, WAYS=2, cache_idle_i=1, req raised at T0:
  - 8 meta reads, no meta_we_o, no evict_req_o.
  - Ack at T0+18, single cycle; busy deasserts at T0+19.
- Same geometry, set2/way1 valid clean, tag 0x1A: exactly one meta_we_o (set=2, way=1), zero evictions, ack at T0+19.
- Set1/way0 dirty, tag 0x3F, LINE_BYTES=64:
  - evict_addr_o = {0x3F,2'b01,6'b0}.
  - Grant withheld 5 cycles: request and payload stay stable.
  - Done 3 cycles after grant: one meta_we_o, then walk resumes at set1/way1.
- cache_idle_i low for 10 cycles after req: busy=1, no meta_rd_o until idle rises.
- req held high 20 cycles after ack: no second walk. Drop req, raise again: a new walk starts from set0/way0.
- rst_i asserted during WB_WAIT: all outputs 0 immediately, no ack; after release, a new req performs a full walk.
